// File: rtl/ddsseq_pkg.sv
// Shared types and constants for the DDS tuning-word sequencer.
// Contents: FSM state enum, half-select codes for dds_choice,
// word/half-word widths and a counter-width helper.
package ddsseq_pkg;

    localparam int WORD_W = 32;
    localparam int HALF_W = 16;

    localparam logic CHOICE_LO = 1'b0;
    localparam logic CHOICE_HI = 1'b1;

    typedef enum logic [2:0] {
        RST,
        IDLE,
        PREP,
        LOAD_LO,
        GAP,
        LOAD_HI,
        WAIT_FQUD,
        DONE
    } state_e;

    // Counter width that can hold n without wrapping.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/dds_sequencer_if.sv
// Request/acknowledge port used by each requester of the DDS sequencer.
// Signals:
//   req  - level request, held until ack
//   word - 32-bit tuning word, valid while req is high
//   ack  - one-cycle completion pulse from the sequencer
// Modports: master (requester side), slave (sequencer side).
interface dds_sequencer_if;
    import ddsseq_pkg::*;

    logic              req;
    logic [WORD_W-1:0] word;
    logic              ack;

    modport master (output req, output word, input ack);
    modport slave  (input req, input word, output ack);

endinterface

// File: rtl/dds_arb2.sv
// Two-way fairness arbiter for the DDS sequencer.
// Ports:
//   clk, reset      - clock, async active-high reset
//   req_a, req_b    - pending requests (A = pulse sequencer, B = host)
//   grant_en        - arbitration is performed only while high
//   grant[1:0]      - one-hot grant, bit 0 = A, bit 1 = B (combinational)
//   last_a          - history flag: previous grant went to A while B waited
module dds_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       grant_en,
    output logic [1:0] grant,
    output logic       last_a
);

    logic last_a_q;
    logic last_a_d;

    // A wins ties unless it already beat a waiting B last time.
    always_comb begin
        grant    = 2'b00;
        last_a_d = last_a_q;
        if (grant_en) begin
            if (req_a && req_b) begin
                grant = last_a_q ? 2'b10 : 2'b01;
            end else if (req_a) begin
                grant = 2'b01;
            end else if (req_b) begin
                grant = 2'b10;
            end
            if (grant != 2'b00) begin
                last_a_d = grant[0] & req_b;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_a_q <= 1'b0;
        end else begin
            last_a_q <= last_a_d;
        end
    end

    assign last_a = last_a_q;

endmodule

// File: rtl/dds_sequencer.sv
// DDS frequency-tuning update sequencer.
// Shares the DDS serial configuration path between the pulse sequencer
// (a_port) and the host (b_port), runs the DDS power-up reset, loads the
// tuning word as two half-words, waits for ddsfqud and gates the
// configuration clock off once idle.
// Ports:
//   clk, reset        - system clock, async active-high reset
//   a_port, b_port    - requester handshakes (req/word/ack)
//   dds_fqud          - completion from the DDS config block
//   dds_reset         - reset to the DDS config block
//   dds_clken         - DDS config clock enable
//   dds_load          - one-cycle load strobe
//   dds_choice        - half select for dds_datain (0 = low, 1 = high)
//   dds_datain        - half-word to the DDS config block
//   busy              - high whenever the FSM is not idle
//   timeout_err       - sticky completion-timeout flag
//   err_clr           - clears timeout_err
module dds_sequencer
    import ddsseq_pkg::*;
#(
    parameter int RST_CYCLES = 16,
    parameter int GAP_CYCLES = 40,
    parameter int TIMEOUT    = 1023,
    parameter int CLKEN_TAIL = 8
) (
    input  logic               clk,
    input  logic               reset,
    dds_sequencer_if.slave     a_port,
    dds_sequencer_if.slave     b_port,
    input  logic               dds_fqud,
    output logic               dds_reset,
    output logic               dds_clken,
    output logic               dds_load,
    output logic               dds_choice,
    output logic [HALF_W-1:0]  dds_datain,
    output logic               busy,
    output logic               timeout_err,
    input  logic               err_clr
);

    localparam int CNT_MAX = (RST_CYCLES > GAP_CYCLES) ?
                             ((RST_CYCLES > TIMEOUT) ? RST_CYCLES : TIMEOUT) :
                             ((GAP_CYCLES > TIMEOUT) ? GAP_CYCLES : TIMEOUT);
    localparam int CNT_W   = cnt_width(CNT_MAX);
    localparam int TAIL_W  = cnt_width(CLKEN_TAIL);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TAIL_W-1:0]   tail_q, tail_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                sel_b_q, sel_b_d;
    logic                timeout_txn_q, timeout_txn_d;
    logic                fqud_prev_q, fqud_prev_d;
    logic                dds_reset_q, dds_reset_d;
    logic                dds_clken_q, dds_clken_d;
    logic                dds_load_q, dds_load_d;
    logic                dds_choice_q, dds_choice_d;
    logic [HALF_W-1:0]   dds_datain_q, dds_datain_d;
    logic                busy_q, busy_d;
    logic                timeout_err_q, timeout_err_d;
    logic                a_ack_q, a_ack_d;
    logic                b_ack_q, b_ack_d;

    logic [1:0]          grant;
    logic                arb_history_unused;
    logic                fqud_edge;
    logic                timeout_hit;

    // Arbitration history is kept inside the arbiter; it is exposed only
    // for observability.
    dds_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .req_a    (a_port.req),
        .req_b    (b_port.req),
        .grant_en (state_q == IDLE),
        .grant    (grant),
        .last_a   (arb_history_unused)
    );

    assign fqud_edge = dds_fqud & ~fqud_prev_q;

    // Next-state logic; every output is computed from the next state so the
    // registered copy lines up with the state it belongs to.
    always_comb begin
        state_d       = state_q;
        word_d        = word_q;
        sel_b_d       = sel_b_q;
        timeout_txn_d = timeout_txn_q;
        timeout_hit   = 1'b0;
        fqud_prev_d   = dds_fqud;
        timeout_err_d = err_clr ? 1'b0 : timeout_err_q;

        case (state_q)
            RST: begin
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = IDLE;
            end
            IDLE: begin
                if (grant != 2'b00) begin
                    state_d = PREP;
                    sel_b_d = grant[1];
                    word_d  = grant[1] ? b_port.word : a_port.word;
                end
            end
            PREP: begin
                if (cnt_q == CNT_W'(1)) state_d = LOAD_LO;
            end
            LOAD_LO: state_d = GAP;
            GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) state_d = LOAD_HI;
            end
            LOAD_HI: state_d = WAIT_FQUD;
            WAIT_FQUD: begin
                if (fqud_edge) begin
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d     = DONE;
                    timeout_hit = 1'b1;
                end
            end
            DONE: begin
                state_d       = timeout_txn_q ? RST : IDLE;
                timeout_txn_d = 1'b0;
            end
            default: state_d = RST;
        endcase

        // A timeout outranks a simultaneous err_clr.
        if (timeout_hit) begin
            timeout_err_d = 1'b1;
            timeout_txn_d = 1'b1;
        end

        // Counter restarts on every state change and is held in IDLE.
        if (state_d != state_q || state_q == IDLE) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Tail is reloaded while active and drains through the IDLE cycles.
        if (state_d != IDLE) begin
            tail_d = TAIL_W'(CLKEN_TAIL);
        end else if (tail_q != '0) begin
            tail_d = tail_q - TAIL_W'(1);
        end else begin
            tail_d = '0;
        end

        dds_reset_d  = (state_d == RST);
        dds_clken_d  = (state_d != IDLE) || (tail_q != '0);
        busy_d       = (state_d != IDLE);
        dds_load_d   = (state_d == LOAD_LO) || (state_d == LOAD_HI);
        dds_choice_d = dds_choice_q;
        dds_datain_d = dds_datain_q;
        if (state_d == LOAD_LO) begin
            dds_choice_d = CHOICE_LO;
            dds_datain_d = word_q[HALF_W-1:0];
        end else if (state_d == LOAD_HI) begin
            dds_choice_d = CHOICE_HI;
            dds_datain_d = word_q[WORD_W-1:HALF_W];
        end
        a_ack_d = (state_d == DONE) && !sel_b_q;
        b_ack_d = (state_d == DONE) && sel_b_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RST;
            cnt_q         <= '0;
            tail_q        <= TAIL_W'(CLKEN_TAIL);
            word_q        <= '0;
            sel_b_q       <= 1'b0;
            timeout_txn_q <= 1'b0;
            fqud_prev_q   <= 1'b0;
            dds_reset_q   <= 1'b1;
            dds_clken_q   <= 1'b1;
            dds_load_q    <= 1'b0;
            dds_choice_q  <= 1'b0;
            dds_datain_q  <= '0;
            busy_q        <= 1'b1;
            timeout_err_q <= 1'b0;
            a_ack_q       <= 1'b0;
            b_ack_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tail_q        <= tail_d;
            word_q        <= word_d;
            sel_b_q       <= sel_b_d;
            timeout_txn_q <= timeout_txn_d;
            fqud_prev_q   <= fqud_prev_d;
            dds_reset_q   <= dds_reset_d;
            dds_clken_q   <= dds_clken_d;
            dds_load_q    <= dds_load_d;
            dds_choice_q  <= dds_choice_d;
            dds_datain_q  <= dds_datain_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            a_ack_q       <= a_ack_d;
            b_ack_q       <= b_ack_d;
        end
    end

    assign dds_reset   = dds_reset_q;
    assign dds_clken   = dds_clken_q;
    assign dds_load    = dds_load_q;
    assign dds_choice  = dds_choice_q;
    assign dds_datain  = dds_datain_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
    assign a_port.ack  = a_ack_q;
    assign b_port.ack  = b_ack_q;

endmodule

// File: tb/tb_dds_sequencer.sv
// Self-checking bench for dds_sequencer: table-driven transactions,
// hand-written corner sequences and randomized transactions checked
// against a transaction-level reference model.
module tb_dds_sequencer;

    localparam int RST_CYCLES = 16;
    localparam int GAP_CYCLES = 40;
    localparam int TIMEOUT    = 1023;
    localparam int CLKEN_TAIL = 8;

    logic        clk;
    logic        reset;
    logic        dds_fqud;
    logic        dds_reset;
    logic        dds_clken;
    logic        dds_load;
    logic        dds_choice;
    logic [15:0] dds_datain;
    logic        busy;
    logic        timeout_err;
    logic        err_clr;

    dds_sequencer_if a_if ();
    dds_sequencer_if b_if ();

    dds_sequencer #(
        .RST_CYCLES (RST_CYCLES),
        .GAP_CYCLES (GAP_CYCLES),
        .TIMEOUT    (TIMEOUT),
        .CLKEN_TAIL (CLKEN_TAIL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .a_port      (a_if.slave),
        .b_port      (b_if.slave),
        .dds_fqud    (dds_fqud),
        .dds_reset   (dds_reset),
        .dds_clken   (dds_clken),
        .dds_load    (dds_load),
        .dds_choice  (dds_choice),
        .dds_datain  (dds_datain),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]  mask;
        logic [31:0] wa;
        logic [31:0] wb;
        int          delay;
        bit          glitch;
        bit          expB;
        logic [15:0] expLo;
        logic [15:0] expHi;
    } vec_t;

    int  errCount;
    int  checkCount;
    bit  expTimeoutErr;

    // Reference arbitration history: who won last and whether B was waiting.
    bit  modelLastWasA;
    bit  modelBWaited;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        modelLastWasA = 1'b0;
        modelBWaited  = 1'b0;
    endtask

    task automatic modelArbitrate(input logic [1:0] mask, output bit grantB);
        if (mask == 2'b11) grantB = (modelLastWasA && modelBWaited);
        else               grantB = (mask == 2'b10);
        modelLastWasA = !grantB;
        modelBWaited  = mask[1];
    endtask

    task automatic waitIdle(output int acks);
        int n;
        acks = 0;
        n = 0;
        while (busy && n < 200) begin
            step();
            n++;
            if (a_if.ack || b_if.ack) acks++;
        end
        if (busy) checkOutput("idle wait bound", busy, 0);
    endtask

    // One full transaction from the IDLE cycle (cycle 0) to its DONE cycle.
    task automatic applyStimulus(input logic [1:0] mask, input logic [31:0] wa, input logic [31:0] wb,
                                 input int delay, input bit glitch, input bit dropAfter,
                                 input bit clrAtTimeout, input bit expB,
                                 input logic [15:0] expLo, input logic [15:0] expHi);
        int hiCyc, fqCyc, ackCyc, aCnt, bCnt, loads, dummy;
        waitIdle(dummy);
        hiCyc  = 4 + GAP_CYCLES;
        fqCyc  = (delay < 0) ? -1 : hiCyc + delay;
        ackCyc = (delay < 0) ? hiCyc + TIMEOUT + 1 : fqCyc + 1;
        aCnt = 0; bCnt = 0; loads = 0;
        a_if.req  = mask[0];
        a_if.word = wa;
        b_if.req  = mask[1];
        b_if.word = wb;
        for (int k = 0; k <= ackCyc; k++) begin
            if (k > 0) step();
            if (k == fqCyc) dds_fqud = 1'b1;
            if (glitch && k == 8)  dds_fqud = 1'b1;
            if (glitch && k == 10) dds_fqud = 1'b0;
            if (dropAfter && k == 5) begin
                if (expB) b_if.req = 1'b0;
                else      a_if.req = 1'b0;
            end
            if (clrAtTimeout && k == ackCyc - 1) err_clr = 1'b1;
            if (k == ackCyc) err_clr = 1'b0;
            if (dds_load)  loads++;
            if (a_if.ack)  aCnt++;
            if (b_if.ack)  bCnt++;
            if (k == 1) checkOutput("busy in PREP", busy, 1);
            if (k == 3) begin
                checkOutput("LOAD_LO strobe", dds_load, 1);
                checkOutput("LOAD_LO choice", dds_choice, 0);
                checkOutput("LOAD_LO datain", dds_datain, expLo);
            end
            if (k == hiCyc - 1) begin
                checkOutput("GAP load low", dds_load, 0);
                checkOutput("GAP datain hold", dds_datain, expLo);
            end
            if (k == hiCyc) begin
                checkOutput("LOAD_HI strobe", dds_load, 1);
                checkOutput("LOAD_HI choice", dds_choice, 1);
                checkOutput("LOAD_HI datain", dds_datain, expHi);
            end
            if (k == ackCyc) begin
                if (delay < 0) expTimeoutErr = 1'b1;
                checkOutput("ack port {b,a}", {b_if.ack, a_if.ack}, expB ? 2'b10 : 2'b01);
                checkOutput("timeout_err at DONE", timeout_err, expTimeoutErr);
                if (expB) b_if.req = 1'b0;
                else      a_if.req = 1'b0;
            end
        end
        dds_fqud = 1'b0;
        checkOutput("load strobes per txn", loads, 2);
        checkOutput("a_ack count", aCnt, expB ? 0 : 1);
        checkOutput("b_ack count", bCnt, expB ? 1 : 0);
    endtask

    initial begin
        vec_t vecs[6];
        int   n, acks, busyCnt;
        bit   gB;
        logic [1:0]  mask;
        logic [31:0] wa, wb, w;
        int   dly;
        bit   drop;

        errCount = 0;
        checkCount = 0;
        expTimeoutErr = 1'b0;
        modelReset();

        vecs[0] = '{2'b01, 32'h12345678, 32'h00000000, 20, 1'b0, 1'b0, 16'h5678, 16'h1234};
        vecs[1] = '{2'b11, 32'hA1A2A3A4, 32'hB1B2B3B4,  5, 1'b1, 1'b0, 16'hA3A4, 16'hA1A2};
        vecs[2] = '{2'b11, 32'hA5A6A7A8, 32'hB5B6B7B8, 12, 1'b0, 1'b1, 16'hB7B8, 16'hB5B6};
        vecs[3] = '{2'b11, 32'hCAFEF00D, 32'hDEADBEEF,  1, 1'b0, 1'b0, 16'hF00D, 16'hCAFE};
        vecs[4] = '{2'b11, 32'h0F0F0F0F, 32'hFFFF0000, 30, 1'b0, 1'b1, 16'h0000, 16'hFFFF};
        vecs[5] = '{2'b10, 32'h00000000, 32'h89ABCDEF,  3, 1'b0, 1'b1, 16'hCDEF, 16'h89AB};

        reset = 1'b1;
        dds_fqud = 1'b0;
        err_clr = 1'b0;
        a_if.req = 1'b0; a_if.word = '0;
        b_if.req = 1'b0; b_if.word = '0;
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] reset values");
        checkOutput("reset dds_reset", dds_reset, 1);
        checkOutput("reset dds_clken", dds_clken, 1);
        checkOutput("reset busy", busy, 1);
        checkOutput("reset dds_load", dds_load, 0);
        checkOutput("reset datain", dds_datain, 0);
        checkOutput("reset acks", {b_if.ack, a_if.ack}, 0);
        checkOutput("reset timeout_err", timeout_err, 0);

        reset = 1'b0;
        n = 0;
        while (dds_reset && n < 100) begin n++; step(); end
        checkOutput("power-up dds_reset cycles", n, RST_CYCLES);
        checkOutput("idle busy", busy, 0);
        n = 0;
        while (dds_clken && n < 100) begin n++; step(); end
        checkOutput("clken tail cycles", n, CLKEN_TAIL);

        $display("[TB] table vectors");
        for (int i = 0; i < 6; i++) begin
            modelArbitrate(vecs[i].mask, gB);
            applyStimulus(vecs[i].mask, vecs[i].wa, vecs[i].wb, vecs[i].delay, vecs[i].glitch,
                          1'b0, 1'b0, vecs[i].expB, vecs[i].expLo, vecs[i].expHi);
        end

        $display("[TB] reset during GAP");
        waitIdle(acks);
        a_if.req = 1'b1; a_if.word = 32'h11112222;
        b_if.req = 1'b1; b_if.word = 32'h33334444;
        repeat (10) step();
        checkOutput("pre-abort datain", dds_datain, 16'h2222);
        reset = 1'b1;
        #2;
        checkOutput("abort dds_reset", dds_reset, 1);
        checkOutput("abort dds_clken", dds_clken, 1);
        checkOutput("abort busy", busy, 1);
        checkOutput("abort datain", dds_datain, 0);
        checkOutput("abort acks", {b_if.ack, a_if.ack}, 0);
        a_if.req = 1'b0;
        b_if.req = 1'b0;
        modelReset();
        expTimeoutErr = 1'b0;
        step(); step();
        reset = 1'b0;
        waitIdle(acks);
        checkOutput("no ack after abort", acks, 0);
        modelArbitrate(2'b11, gB);
        applyStimulus(2'b11, 32'h11112222, 32'h33334444, 7, 1'b0, 1'b0, 1'b0, gB,
                      gB ? 16'h4444 : 16'h2222, gB ? 16'h3333 : 16'h1111);

        $display("[TB] random transactions");
        for (int i = 0; i < 8; i++) begin
            mask = 2'($urandom_range(1, 3));
            wa   = $urandom;
            wb   = $urandom;
            dly  = $urandom_range(1, 30);
            drop = 1'($urandom_range(0, 1));
            modelArbitrate(mask, gB);
            w = gB ? wb : wa;
            applyStimulus(mask, wa, wb, dly, 1'b0, drop, 1'b0, gB, w[15:0], w[31:16]);
        end

        $display("[TB] timeout with simultaneous err_clr");
        modelArbitrate(2'b01, gB);
        applyStimulus(2'b01, 32'h0BADF00D, 32'h0, -1, 1'b0, 1'b0, 1'b1, gB, 16'hF00D, 16'h0BAD);
        n = 0;
        step();
        while (dds_reset && n < 100) begin
            n++;
            if (n == 3) b_if.req = 1'b1;
            if (n == 5) b_if.req = 1'b0;
            step();
        end
        checkOutput("post-timeout dds_reset cycles", n, RST_CYCLES);
        checkOutput("timeout_err sticky", timeout_err, 1);
        acks = 0;
        busyCnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (busy) busyCnt++;
            if (a_if.ack || b_if.ack) acks++;
            step();
        end
        checkOutput("withdrawn request busy", busyCnt, 0);
        checkOutput("withdrawn request acks", acks, 0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        expTimeoutErr = 1'b0;
        checkOutput("err_clr clears", timeout_err, 0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/dds_sequencer.md
# dds_sequencer

Schedules DDS frequency-tuning updates and shares the DDS serial-configuration path between two requesters: the NMR pulse sequencer (port A) and the host/MCU register interface (port B). It drives the `dds_load`/`dds_choice`/`dds_datain`/`dds_clken`/`dds_reset` inputs of the DDS configuration block and watches its `ddsfqud` output as completion. It also runs the power-up DDS reset sequence, and gates the configuration clock off when idle to keep switching noise out of the receive window.

## Interface
- `RST_CYCLES`, default 16: cycles `dds_reset` is held high in RST.
- `GAP_CYCLES`, default 40: idle cycles between the low-half and high-half loads, covering the 16-bit shift-out.
- `TIMEOUT`, default 1023: maximum WAIT_FQUD cycles.
- `CLKEN_TAIL`, default 8: cycles `dds_clken` stays high after DONE.
- `clk` in 1: system clock; the DDS configuration path is gated from this same clock.
- `reset` in 1: asynchronous, active-high.
- `a_req` in 1: sequencer request; level, held until `a_ack`.
- `a_word` in 32: sequencer tuning word.
- `a_ack` out 1: one-cycle completion pulse.
- `b_req`, `b_word`, `b_ack`: host port, same widths and rules as port A.
- `dds_fqud` in 1: `ddsfqud` from the config block, synchronous to `clk`.
- `dds_reset` out 1: reset to the config block.
- `dds_clken` out 1: config clock enable.
- `dds_load` out 1: one-cycle load strobe.
- `dds_choice` out 1: 0 = low half, 1 = high half.
- `dds_datain` out 16: half-word to the config block.
- `busy` out 1: high in every state except IDLE.
- `timeout_err` out 1: sticky; set on a WAIT_FQUD timeout.
- `err_clr` in 1: clears `timeout_err`.

## Operation
- All outputs are registered.
- Reset values: state RST, `dds_reset`=1, `dds_clken`=1, `busy`=1. All other outputs 0.
- **RST:** `dds_reset`=1 and `dds_clken`=1 for `RST_CYCLES`, then go to IDLE.
- **IDLE:** arbitrate.
  - If only one request is pending, grant it.
  - If both are pending, grant A, unless the previous grant was A while B was pending; then grant B. Continuous contention therefore alternates.
  - On grant, latch the selected word into `word_q` and go to PREP.
- **PREP:** 2 cycles with `dds_clken`=1.
- **LOAD_LO:** 1 cycle, `dds_load`=1, `dds_choice`=0, `dds_datain`=`word_q[15:0]`.
- **GAP:** `GAP_CYCLES` cycles.
- **LOAD_HI:** 1 cycle, `dds_load`=1, `dds_choice`=1, `dds_datain`=`word_q[31:16]`.
- **WAIT_FQUD:**
  - Detect a rising edge of `dds_fqud` (`dds_fqud & ~fqud_d`); on the edge, go to DONE.
  - After `TIMEOUT` cycles with no edge, set `timeout_err` and go to DONE.
- **DONE:** 1 cycle; `ack` of the granted port = 1.
  - Next state is IDLE, or RST if this transaction timed out.
- `dds_datain`/`dds_choice` hold their last value outside the load states. `dds_load` is 0 elsewhere.
- `dds_clken`:
  - 1 in RST, PREP, LOAD_*, GAP, WAIT_FQUD and DONE.
  - After DONE it stays 1 for `CLKEN_TAIL` cycles, then drops to 0.
  - A new grant during the tail keeps it high continuously.

## Timing
- Let cycle 0 be IDLE with `req` high. Then PREP occupies cycles 1–2, LOAD_LO is cycle 3, GAP is cycles 4..3+`GAP_CYCLES`, and LOAD_HI is cycle 4+`GAP_CYCLES`.
- An `fqud` rise at cycle n gives DONE (ack) at cycle n+1.
- The requester drops `req` on the edge after it samples `ack`. The following IDLE cycle evaluates `req`, so a `req` still high there is a new request.
- Dropping `req` after grant has no effect: the transaction completes and ack still pulses.
- Dropping `req` before grant withdraws the request; no ack is issued.
- `err_clr` and a timeout set in the same cycle: set wins.
- `fqud` edges outside WAIT_FQUD are ignored. `fqud_d` still tracks them.
- `reset` asserted mid-transaction: immediately return to RST, no ack issued, and the arbitration history is cleared to "last = B". Requesters re-issue their requests.
- Counters are sized to `$clog2` of their parameter plus 1 and never wrap.

## Structure
- Package `ddsseq_pkg` holds:
  - state enum: RST, IDLE, PREP, LOAD_LO, GAP, LOAD_HI, WAIT_FQUD, DONE;
  - `CHOICE_LO`=0 and `CHOICE_HI`=1;
  - `WORD_W`=32 and `HALF_W`=16.
- Sub-module `dds_arb2`: the 2-way fairness arbiter.
  - Inputs: `req_a`, `req_b`, `grant_en`.
  - Outputs: one-hot grant, plus a `last_a` register.
- The FSM, counters, edge detect and clock-enable tail live in `dds_sequencer`.

## Test plan
- After reset: `dds_reset`=1 for 16 cycles, `dds_clken`=1, then IDLE with `busy`=0, and `dds_clken` falls 8 cycles later.
- A-only request, `a_word`=0x12345678, `fqud` rising 20 cycles after LOAD_HI:
  - LOAD_LO at cycle 3 with datain 0x5678, choice 0;
  - LOAD_HI at cycle 44 with datain 0x1234, choice 1;
  - `a_ack` at cycle 65.
- A and B held high together for 4 transactions: grant order A, B, A, B, with exactly one ack each.
- No `fqud`: `timeout_err`=1 after 1023 WAIT cycles, ack issued, FSM re-enters RST (`dds_reset`=1 for 16 cycles).
- `err_clr` pulsed in the same cycle as the timeout: `timeout_err`=1. A later lone `err_clr` gives `timeout_err`=0.
- `reset` pulsed during GAP: outputs return to their reset values, no ack, and the request re-issued afterwards completes normally.
